// File: rtl/mult_arbiter.sv
// Round-robin front end sharing one shift-add multiplier among N_REQ clients.
// Sequences the multiplier reset, guards the run with a timeout, returns tagged results.
module mult_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*WIDTH-1:0]      req_a,
  input  logic [N_REQ*WIDTH-1:0]      req_b,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(N_REQ)-1:0]    rsp_id,
  output logic [2*WIDTH-1:0]          rsp_result,
  output logic                        rsp_err,
  output logic                        mul_rst,
  output logic [WIDTH-1:0]            mul_multiplicand,
  output logic [WIDTH-1:0]            mul_multiplier,
  input  logic [2*WIDTH-1:0]          mul_result,
  input  logic                        mul_end_op
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [IW-1:0]      r_last;
  logic               r_load_cnt;
  logic [CW-1:0]      r_run_cnt;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [IW-1:0]      r_id;
  logic [2*WIDTH-1:0] r_res;
  logic               r_err;
  logic               r_vld;
  logic               r_mrst;

  logic               w_found;
  logic [IW-1:0]      w_gnt_idx;
  logic [IW-1:0]      w_cand;
  logic [N_REQ-1:0]   w_gnt;

  // Search starts one past the last winner and wraps.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = IW'((int'(r_last) + k) % N_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_gnt = '0;
    if (r_state == S_IDLE && w_found && !rst)
      w_gnt = N_REQ'(1) << w_gnt_idx;
  end

  assign req_ready        = w_gnt;
  assign rsp_valid        = r_vld;
  assign rsp_id           = r_id;
  assign rsp_result       = r_res;
  assign rsp_err          = r_err;
  assign mul_rst          = r_mrst;
  assign mul_multiplicand = r_opa;
  assign mul_multiplier   = r_opb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last     <= IW'(N_REQ - 1);
      r_load_cnt <= 1'b0;
      r_run_cnt  <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_id       <= '0;
      r_res      <= '0;
      r_err      <= 1'b0;
      r_vld      <= 1'b0;
      r_mrst     <= 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_opa      <= req_a[int'(w_gnt_idx)*WIDTH +: WIDTH];
            r_opb      <= req_b[int'(w_gnt_idx)*WIDTH +: WIDTH];
            r_id       <= w_gnt_idx;
            r_last     <= w_gnt_idx;
            r_load_cnt <= 1'b0;
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (r_load_cnt) begin
            r_mrst    <= 1'b0;
            r_run_cnt <= '0;
            r_state   <= S_RUN;
          end else begin
            r_load_cnt <= 1'b1;
          end
        end
        S_RUN: begin
          r_run_cnt <= r_run_cnt + 1'b1;
          // A finishing multiplier wins over a coincident timeout.
          if (mul_end_op) begin
            r_res   <= mul_result;
            r_err   <= 1'b0;
            r_vld   <= 1'b1;
            r_mrst  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_run_cnt == CW'(TIMEOUT - 1)) begin
            r_res   <= '0;
            r_err   <= 1'b1;
            r_vld   <= 1'b1;
            r_mrst  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            r_vld   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized bench for mult_arbiter with a behavioural multiplier stub
// and a transaction-level round-robin / timing reference model.
module tb_mult_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 32;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [2*W-1:0]  rsp_result;
  logic            rsp_err;
  logic            mul_rst;
  logic [W-1:0]    mul_multiplicand;
  logic [W-1:0]    mul_multiplier;
  logic [2*W-1:0]  mul_result;
  logic            mul_end_op;

  mult_arbiter #(
    .N_REQ   (N),
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_a            (req_a),
    .req_b            (req_b),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_id           (rsp_id),
    .rsp_result       (rsp_result),
    .rsp_err          (rsp_err),
    .mul_rst          (mul_rst),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_result       (mul_result),
    .mul_end_op       (mul_end_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier stub: finishes lat_r cycles after leaving reset unless stalled.
  logic       stall;
  logic [7:0] lat_r;
  logic [7:0] s_cnt;

  always_ff @(posedge clk) begin
    if (mul_rst) s_cnt <= '0;
    else if (s_cnt != 8'hFF) s_cnt <= s_cnt + 8'd1;
  end

  assign mul_end_op = !mul_rst && !stall && (s_cnt == lat_r);
  assign mul_result = mul_end_op ?
    16'(mul_multiplicand) * 16'(mul_multiplier) : 16'hDEAD;

  int n_vec = 0;
  int n_err = 0;
  int m_last;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_grant();
    for (int k = 1; k <= N; k++)
      if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
    return 0;
  endfunction

  task automatic setreq(input int i, input logic [7:0] x, input logic [7:0] y);
    req_valid[i]     = 1'b1;
    req_a[i*W +: W]  = x;
    req_b[i*W +: W]  = y;
  endtask

  task automatic one_op(input logic [7:0] lat, input logic st, input int bp);
    int         g;
    int         t;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [15:0] ep;
    stall = st;
    lat_r = lat;
    #1;
    g  = exp_grant();
    ea = req_a[g*W +: W];
    eb = req_b[g*W +: W];
    ep = 16'(ea) * 16'(eb);
    check("grant", 32'(req_ready), 32'(1) << g);
    @(posedge clk);
    #1;
    req_valid[g] = 1'b0;
    m_last = g;
    @(negedge clk);
    check("load1_mrst", 32'(mul_rst), 1);
    check("busy_rdy", 32'(req_ready), 0);
    @(negedge clk);
    check("load2_mrst", 32'(mul_rst), 1);
    check("opa", 32'(mul_multiplicand), 32'(ea));
    check("opb", 32'(mul_multiplier), 32'(eb));
    @(negedge clk);
    check("run_mrst", 32'(mul_rst), 0);
    check("run_vld", 32'(rsp_valid), 0);
    rsp_ready = (bp == 0);
    t = 3;
    while (!rsp_valid && t < TO + 12) begin
      @(negedge clk);
      t++;
    end
    check("rise_cyc", 32'(t), st ? 32'(TO + 3) : 32'(lat) + 32'd4);
    check("rsp_vld", 32'(rsp_valid), 1);
    check("rsp_id", 32'(rsp_id), 32'(g));
    check("rsp_res", 32'(rsp_result), st ? 32'd0 : 32'(ep));
    check("rsp_err", 32'(rsp_err), 32'(st));
    check("done_rdy", 32'(req_ready), 0);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_vld", 32'(rsp_valid), 1);
      check("bp_res", 32'(rsp_result), st ? 32'd0 : 32'(ep));
      check("bp_rdy", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("idle_vld", 32'(rsp_valid), 0);
  endtask

  initial begin
    int  r;
    bit  seen;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    stall     = 1'b0;
    lat_r     = 8'd0;
    m_last    = N - 1;
    #1;
    check("rst_mrst", 32'(mul_rst), 1);
    check("rst_vld", 32'(rsp_valid), 0);
    check("rst_id", 32'(rsp_id), 0);
    check("rst_res", 32'(rsp_result), 0);
    check("rst_err", 32'(rsp_err), 0);
    check("rst_opa", 32'(mul_multiplicand), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_rdy", 32'(req_ready), 0);
      check("idle_mrst", 32'(mul_rst), 1);
    end

    // Fairness: two simultaneous rounds of req0 and req2
    setreq(0, 10, 12);
    setreq(2, 13, 11);
    one_op(3, 0, 0);
    one_op(5, 0, 0);
    setreq(0, 10, 12);
    setreq(2, 13, 11);
    one_op(2, 0, 1);
    one_op(0, 0, 0);

    setreq(0, 3, 5);
    one_op(4, 0, 0);
    setreq(3, 255, 255);
    one_op(6, 0, 0);
    setreq(1, 0, 123);
    one_op(1, 0, 0);
    setreq(2, 127, 201);
    one_op(5, 0, 10);
    setreq(1, 77, 3);
    one_op(0, 1, 0);
    setreq(0, 9, 9);
    one_op(8'(TO - 1), 0, 0);

    // Reset during RUN drops the operation silently
    setreq(0, 3, 5);
    stall = 1'b0;
    lat_r = 8'd10;
    #1;
    check("rst_grant", 32'(req_ready), 1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_mrst", 32'(mul_rst), 0);
    rst = 1'b1;
    #1;
    check("arst_vld", 32'(rsp_valid), 0);
    check("arst_mrst", 32'(mul_rst), 1);
    check("arst_rdy", 32'(req_ready), 0);
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    m_last = N - 1;
    seen   = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("ghost_rsp", 32'(seen), 0);
    setreq(2, 6, 7);
    setreq(0, 3, 5);
    one_op(3, 0, 0);
    one_op(2, 0, 0);

    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1)
          setreq(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      if (req_valid == '0)
        setreq(int'($urandom_range(0, N - 1)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)));
      r = int'($urandom_range(0, 9));
      one_op(r == 0 ? 8'(TO - 1) : 8'($urandom_range(0, 12)), r == 1,
             int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
